// File: rtl/sram_like_responder_pkg.sv
// sram_like_pkg: shared types and constants for the sram-like bus responder.
//   - SZ_BYTE/SZ_HALF/SZ_WORD : encodings of the informational size field
//   - CNT_W / QCNT_W / PTR_W  : widths of latency counters, queue count, pointers
//   - entry_t                 : one outstanding transaction (valid, is_wr, data, cnt)
//   - LFSR_SEED / lfsr_next   : latency-jitter LFSR used when SRAM_RESP_RAND_DELAY_EN is defined
package sram_like_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Counter holds LAT-1 plus up to 3 of jitter; 8 bits covers LAT up to 252.
    localparam int CNT_W  = 8;
    // Queue depth is at most 4, so the count needs 3 bits and pointers 2 bits.
    localparam int QCNT_W = 3;
    localparam int PTR_W  = 2;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef struct packed {
        logic             valid;
        logic             is_wr;
        logic [31:0]      data;
        logic [CNT_W-1:0] cnt;
    } entry_t;

    // Fibonacci LFSR, polynomial x^16 + x^14 + x^13 + x^11 + 1 (maximal length).
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

// File: rtl/sram_like_responder_if.sv
// sram_like_if: request/response signals of the CPU sram-like bus.
//   master drives : req, wr, size, wstrb, addr, wdata
//   slave drives  : addr_ok, data_ok, rdata
// Handshake: a request is accepted at a rising edge where req & addr_ok are
// both 1; until then the master holds req and all request fields stable.
// addr_ok never depends on req. data_ok is a one-cycle pulse per accepted
// request, returned in acceptance order, and cannot be back-pressured; rdata
// is meaningful only while data_ok is 1 on a read.
interface sram_like_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_like_responder_queue.sv
// sram_resp_queue: MAX_OUT-entry circular queue of outstanding transactions.
// Every entry's counter counts down to 0 each cycle; only the head may retire.
//   clk, resetn   : clock, synchronous active-low reset (empties the queue)
//   i_push        : append an entry built from i_push_wr/i_push_data/i_push_cnt
//   i_pop         : retire the head (caller only pops a valid head)
//   o_head        : current head entry
//   o_count       : number of valid entries
//   o_full        : o_count == MAX_OUT
module sram_resp_queue
    import sram_like_pkg::*;
#(
    parameter int MAX_OUT = 2
)
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_push,
    input  logic              i_push_wr,
    input  logic [31:0]       i_push_data,
    input  logic [CNT_W-1:0]  i_push_cnt,
    input  logic              i_pop,
    output entry_t            o_head,
    output logic [QCNT_W-1:0] o_count,
    output logic              o_full
);

    entry_t            r_q [MAX_OUT];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [QCNT_W-1:0] r_count;

    // Pointers wrap at MAX_OUT, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUT - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < MAX_OUT; i++) begin
                r_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < MAX_OUT; i++) begin
                if (i_push && (r_tail == PTR_W'(i))) begin
                    r_q[i] <= '{valid: 1'b1, is_wr: i_push_wr, data: i_push_data, cnt: i_push_cnt};
                end else if (i_pop && (r_head == PTR_W'(i))) begin
                    r_q[i].valid <= 1'b0;
                end else if (r_q[i].cnt != '0) begin
                    // Younger entries keep counting while they wait behind the head.
                    r_q[i].cnt <= r_q[i].cnt - CNT_W'(1);
                end
            end
            if (i_push) begin
                r_tail <= ptr_inc(r_tail);
            end
            if (i_pop) begin
                r_head <= ptr_inc(r_head);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + QCNT_W'(1);
                2'b01:   r_count <= r_count - QCNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        o_head = '0;
        for (int i = 0; i < MAX_OUT; i++) begin
            if (r_head == PTR_W'(i)) begin
                o_head = r_q[i];
            end
        end
    end

    assign o_count = r_count;
    assign o_full  = (r_count == QCNT_W'(MAX_OUT));

endmodule

// File: rtl/sram_like_responder.sv
// sram_like_responder: memory-side responder for the sram-like bus, backed by
// a 2^AW x 32-bit word array. Accepts one request per cycle while fewer than
// MAX_OUT are outstanding and answers in order LAT cycles after acceptance.
//   clk    : clock
//   resetn : synchronous active-low reset (drops outstanding work, keeps array)
//   bus    : sram_like_if.slave (req/wr/size/wstrb/addr/wdata in,
//            addr_ok/data_ok/rdata out)
// Optional: SRAM_RESP_RAND_DELAY_EN adds 0..3 cycles of LFSR jitter per request.
module sram_like_responder
    import sram_like_pkg::*;
#(
    parameter int AW      = 10,
    parameter int MAX_OUT = 2,
    parameter int LAT     = 2
)
(
    input  logic        clk,
    input  logic        resetn,
    sram_like_if.slave  bus
);

    logic [31:0]       r_mem [2**AW];
    logic [AW-1:0]     w_idx;
    logic              w_addr_ok;
    logic              w_accept;
    logic [31:0]       w_rd_word;
    logic [CNT_W-1:0]  w_load_cnt;
    entry_t            w_head;
    logic [QCNT_W-1:0] w_count;
    logic              w_full;
    logic              w_head_ready;
    logic              w_data_ok;
    logic              w_unused_bits;

    assign w_idx     = bus.addr[AW+1:2];
    // No look-ahead at a retiring head: a full queue rejects this cycle.
    assign w_addr_ok = resetn & (w_count < QCNT_W'(MAX_OUT));
    assign w_accept  = bus.req & w_addr_ok;
    assign w_rd_word = r_mem[w_idx];

`ifdef SRAM_RESP_RAND_DELAY_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign w_load_cnt = CNT_W'(LAT - 1) + CNT_W'(r_lfsr[1:0]);
`else
    assign w_load_cnt = CNT_W'(LAT - 1);
`endif

    // Array is deliberately not reset; writes land at the acceptance edge so a
    // later read of the same word samples the new value.
    always_ff @(posedge clk) begin
        if (w_accept && bus.wr) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.wstrb[b]) begin
                    r_mem[w_idx][8*b +: 8] <= bus.wdata[8*b +: 8];
                end
            end
        end
    end

    sram_resp_queue #(
        .MAX_OUT (MAX_OUT)
    ) u_queue (
        .clk         (clk),
        .resetn      (resetn),
        .i_push      (w_accept),
        .i_push_wr   (bus.wr),
        .i_push_data (bus.wr ? 32'h0 : w_rd_word),
        .i_push_cnt  (w_load_cnt),
        .i_pop       (w_head_ready),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_full      (w_full)
    );

    // The response is driven from queue registers: it is high for the one
    // cycle in which the head has counted out, and the head pops at the
    // following edge. Gating with resetn keeps a dropped head silent.
    assign w_head_ready = w_head.valid & (w_head.cnt == '0);
    assign w_data_ok    = resetn & w_head_ready;

    assign bus.addr_ok = w_addr_ok;
    assign bus.data_ok = w_data_ok;
    assign bus.rdata   = (w_data_ok && !w_head.is_wr) ? w_head.data : 32'h0;

    // size is informational and the untranslated address bits are don't-care.
    assign w_unused_bits = ^{bus.size, bus.addr[31:AW+2], bus.addr[1:0], w_full};

endmodule

// File: tb/tb_sram_like_responder.sv
// tb_sram_like_responder: directed bench for sram_like_responder.
// Three instances share one stimulus bus: A (LAT=2), B (LAT=4), C (LAT=1),
// all with MAX_OUT=2. Each phase checks only the instance it targets and
// starts from reset so the other instances cannot disturb it.
module tb_sram_like_responder;

    localparam int LAT_A = 2;
    localparam int LAT_B = 4;
    localparam int LAT_C = 1;
`ifdef SRAM_RESP_RAND_DELAY_EN
    localparam int EXTRA = 3;
`else
    localparam int EXTRA = 0;
`endif

    // ---------------- clock / reset / shared stimulus ----------------
    logic        clk = 1'b0;
    logic        resetn;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;

    always #5 clk = ~clk;

    sram_like_if ifa ();
    sram_like_if ifb ();
    sram_like_if ifc ();

    assign ifa.req = req;  assign ifa.wr = wr;  assign ifa.size = size;
    assign ifa.wstrb = wstrb;  assign ifa.addr = addr;  assign ifa.wdata = wdata;
    assign ifb.req = req;  assign ifb.wr = wr;  assign ifb.size = size;
    assign ifb.wstrb = wstrb;  assign ifb.addr = addr;  assign ifb.wdata = wdata;
    assign ifc.req = req;  assign ifc.wr = wr;  assign ifc.size = size;
    assign ifc.wstrb = wstrb;  assign ifc.addr = addr;  assign ifc.wdata = wdata;

    sram_like_responder #(.AW(10), .MAX_OUT(2), .LAT(LAT_A)) u_dut_a (
        .clk (clk), .resetn (resetn), .bus (ifa)
    );
    sram_like_responder #(.AW(10), .MAX_OUT(2), .LAT(LAT_B)) u_dut_b (
        .clk (clk), .resetn (resetn), .bus (ifb)
    );
    sram_like_responder #(.AW(10), .MAX_OUT(2), .LAT(LAT_C)) u_dut_c (
        .clk (clk), .resetn (resetn), .bus (ifc)
    );

    logic [2:0]  aok_v;
    logic [2:0]  ok_v;
    logic [31:0] rd_v [3];

    assign aok_v = {ifc.addr_ok, ifb.addr_ok, ifa.addr_ok};
    assign ok_v  = {ifc.data_ok, ifb.data_ok, ifa.data_ok};
    assign rd_v[0] = ifa.rdata;
    assign rd_v[1] = ifb.rdata;
    assign rd_v[2] = ifc.rdata;

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_all();
        req    = 1'b0;
        resetn = 1'b0;
        step();
        step();
        resetn = 1'b1;
        #1;
    endtask

    // One isolated transaction on instance sel; checks acceptance, latency,
    // response data and that the pulse lasts one cycle, then idles so every
    // instance has drained before the next call.
    task automatic single(input int sel, input logic w, input logic [31:0] a,
                          input logic [3:0] s, input logic [31:0] d,
                          input int lat, input logic [31:0] exp_rd, input string tag);
        int cyc;
        req = 1'b1; wr = w; addr = a; wstrb = s; wdata = d;
        check({tag, "_aok"}, 32'(aok_v[sel]), 32'd1);
        step();
        req = 1'b0;
        cyc = 1;
        while (!ok_v[sel] && cyc < 12) begin
            step();
            cyc++;
        end
        check({tag, "_lat"}, 32'(cyc), 32'(lat));
        check({tag, "_rdata"}, rd_v[sel], exp_rd);
        step();
        check({tag, "_pulse"}, 32'(ok_v[sel]), 32'd0);
        repeat (5) step();
    endtask

    // ---------------- random scoreboard phase (instance A) ----------------
    task automatic run_random();
        logic [31:0] sh [16];
        logic [31:0] exp_q [$];
        int          acc_q [$];
        int          cyc      = 0;
        int          issued   = 0;
        int          prev     = -100;
        int          drain    = 0;
        int          n_spur   = 0;
        bit          holding  = 1'b0;
        logic [31:0] e;
        int          acc;
        int          lo;
        int          hi;
        int          wi;
        while ((issued < 100 || holding || exp_q.size() != 0) && drain < 60 && cyc < 3000) begin
            if (!holding) begin
                if (issued < 16) begin
                    req = 1'b1; wr = 1'b1; wstrb = 4'hF;
                    addr = {8'($urandom_range(0, 255)), 18'b0, 4'(issued), 2'b00};
                    wdata = $urandom();
                end else if (issued < 100 && $urandom_range(0, 3) != 0) begin
                    req = 1'b1; wr = 1'($urandom_range(0, 1));
                    wstrb = 4'($urandom_range(0, 15));
                    addr = {8'($urandom_range(0, 255)), 18'b0, 4'($urandom_range(0, 15)),
                            2'($urandom_range(0, 3))};
                    wdata = $urandom();
                end else begin
                    req = 1'b0;
                end
            end
            if (req && aok_v[0]) begin
                wi = int'(addr[5:2]);
                if (wr) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wstrb[b]) sh[wi][8*b +: 8] = wdata[8*b +: 8];
                    end
                    exp_q.push_back(32'h0);
                end else begin
                    exp_q.push_back(sh[wi]);
                end
                acc_q.push_back(cyc);
                issued++;
                holding = 1'b0;
            end else begin
                holding = req;
            end
            if (ok_v[0]) begin
                if (exp_q.size() == 0) begin
                    n_spur++;
                end else begin
                    e   = exp_q.pop_front();
                    acc = acc_q.pop_front();
                    lo  = (acc + LAT_A > prev + 1) ? acc + LAT_A : prev + 1;
                    hi  = (acc + LAT_A + EXTRA > prev + 1) ? acc + LAT_A + EXTRA : prev + 1;
                    check("rnd_rdata", rd_v[0], e);
                    check("rnd_lat_in_window", 32'(cyc >= lo && cyc <= hi), 32'd1);
                    prev = cyc;
                end
            end
            step();
            cyc++;
            if (issued >= 100 && !holding) drain++;
        end
        req = 1'b0;
        check("rnd_spurious", 32'(n_spur), 32'd0);
        check("rnd_issued", 32'(issued), 32'd100);
        check("rnd_drained", 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- directed tables ----------------
    bit          st_aok [11] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1};
    bit          st_ok  [11] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0};
    logic [31:0] st_rd  [11] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h11111111, 32'h22222222,
                                 32'h0, 32'h0, 32'h0, 32'h33333333, 32'h0};
    logic [31:0] s_addr [8]  = '{32'h0, 32'h4, 32'h8, 32'h10, 32'h0, 32'h4, 32'h8, 32'h10};
    logic [31:0] s_exp  [8]  = '{32'h11111111, 32'h22222222, 32'h33333333, 32'hDEADAAEF,
                                 32'h11111111, 32'h22222222, 32'h33333333, 32'hDEADAAEF};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1);
    end

    initial begin
        int pulses;
        resetn = 1'b0; req = 1'b0; wr = 1'b0; size = 2'd2;
        wstrb = 4'h0; addr = 32'h0; wdata = 32'h0;

        // Reset state
        step();
        step();
        check("rst_aok_a", 32'(aok_v[0]), 32'd0);
        check("rst_aok_b", 32'(aok_v[1]), 32'd0);
        check("rst_aok_c", 32'(aok_v[2]), 32'd0);
        check("rst_dok_a", 32'(ok_v[0]), 32'd0);
        check("rst_rdata_a", rd_v[0], 32'h0);
        resetn = 1'b1;
        #1;
        check("post_rst_aok_a", 32'(aok_v[0]), 32'd1);

        // Write, read-after-write, partial write, ignored address bits
        single(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, LAT_A, 32'h0, "wr_full");
        single(0, 1'b0, 32'h10, 4'h0, 32'h0, LAT_A, 32'hDEADBEEF, "raw");
        single(0, 1'b1, 32'h10, 4'b0010, 32'h0000AA00, LAT_A, 32'h0, "wr_part");
        single(0, 1'b0, 32'h10, 4'h0, 32'h0, LAT_A, 32'hDEADAAEF, "rd_part");
        single(0, 1'b0, 32'hFFFFF013, 4'h0, 32'h0, LAT_A, 32'hDEADAAEF, "rd_hibits");
        single(0, 1'b1, 32'h0, 4'hF, 32'h11111111, LAT_A, 32'h0, "wr_w0");
        single(0, 1'b1, 32'h4, 4'hF, 32'h22222222, LAT_A, 32'h0, "wr_w1");
        single(0, 1'b1, 32'h8, 4'hF, 32'h33333333, LAT_A, 32'h0, "wr_w2");
        single(2, 1'b0, 32'h4, 4'h0, 32'h0, LAT_C, 32'h22222222, "rd_lat1");
        single(1, 1'b0, 32'h8, 4'h0, 32'h0, LAT_B, 32'h33333333, "rd_lat4");

        // Full stall on B: req held for reads of 0x0, 0x4, 0x8
        reset_all();
        for (int k = 0; k < 11; k++) begin
            req  = (k <= 5);
            wr   = 1'b0;
            addr = (k == 0) ? 32'h0 : (k == 1) ? 32'h4 : 32'h8;
            check($sformatf("stall_aok_%0d", k), 32'(aok_v[1]), 32'(st_aok[k]));
            check($sformatf("stall_dok_%0d", k), 32'(ok_v[1]), 32'(st_ok[k]));
            check($sformatf("stall_rdata_%0d", k), rd_v[1], st_rd[k]);
            step();
        end
        req = 1'b0;

        // Streaming on C: one response per cycle
        reset_all();
        check("stream_idle_dok", 32'(ok_v[2]), 32'd0);
        for (int i = 0; i < 8; i++) begin
            req = 1'b1; wr = 1'b0; addr = s_addr[i];
            check($sformatf("stream_aok_%0d", i), 32'(aok_v[2]), 32'd1);
            step();
            check($sformatf("stream_dok_%0d", i), 32'(ok_v[2]), 32'd1);
            check($sformatf("stream_rdata_%0d", i), rd_v[2], s_exp[i]);
        end
        req = 1'b0;
        step();
        check("stream_end_dok", 32'(ok_v[2]), 32'd0);

        // Reset with a write and a read outstanding on A
        reset_all();
        req = 1'b1; wr = 1'b1; addr = 32'h20; wstrb = 4'hF; wdata = 32'hCAFEF00D;
        check("midrst_aok0", 32'(aok_v[0]), 32'd1);
        step();
        wr = 1'b0; addr = 32'h4;
        check("midrst_aok1", 32'(aok_v[0]), 32'd1);
        step();
        req = 1'b0;
        resetn = 1'b0;
        #1;
        check("midrst_aok_in_rst", 32'(aok_v[0]), 32'd0);
        check("midrst_dok_in_rst", 32'(ok_v[0]), 32'd0);
        step();
        resetn = 1'b1;
        #1;
        check("midrst_aok_after", 32'(aok_v[0]), 32'd1);
        pulses = 0;
        repeat (8) begin
            if (ok_v[0]) pulses++;
            step();
        end
        check("midrst_no_dok", 32'(pulses), 32'd0);
        single(0, 1'b0, 32'h20, 4'h0, 32'h0, LAT_A, 32'hCAFEF00D, "midrst_wr_kept");

        // Random mix against the scoreboard
        reset_all();
        run_random();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
